axi_demux_scheduler: RTL
========================

# axi_demux_scheduler

Packet-level round-robin scheduler that drives the select stream of the AXI stream demultiplexer. It issues one output index per input packet, choosing among enabled outputs that hold a free downstream buffer credit. It observes the demux input handshake to detect packet ends, so the demux never receives a new select token mid-packet. It sits beside the demultiplexer: its `select` master connects to the demux `select` slave, and downstream consumers return credits as they drain packets.

## Interface
- `NUM_STREAMS`, default 4: number of demux outputs; must be ≥ 2.
- `MAX_CREDITS`, default 2: per-output packet-buffer depth; must be ≥ 1.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `select`  ready_valid_i.m  data = $clog2(NUM_STREAMS): output index token to the demux.
- `in_tvalid`, `in_tready`, `in_tlast`  in  1 each: monitor taps on the demux input stream; never driven.
- `out_enable`  in  NUM_STREAMS: per-output eligibility mask.
- `credit_return`  in  NUM_STREAMS: per-output one-cycle pulse; each pulse returns one packet slot.
- `busy`  out  1: high in OFFER and WAIT_LAST.
- `credit_overflow`  out  1: sticky error; set when a return arrives at an output whose counter is already at MAX_CREDITS.

## Operation
- Per-output credit counter, width $clog2(MAX_CREDITS+1). Reset value is MAX_CREDITS.
- An output is eligible when `out_enable[i]` is high and its credit is > 0.
- FSM states: IDLE, OFFER, WAIT_LAST.
  - IDLE: if any output is eligible, pick the first eligible index searching upward from `rr_ptr` with wrap-around. Register the pick into `select.data`, set `select.valid`, and go to OFFER. Otherwise stay in IDLE.
  - OFFER: hold `select.valid` and `select.data` stable until `select.ready`. On the handshake, decrement that output's credit, set `rr_ptr` to (index+1) mod NUM_STREAMS, and go to WAIT_LAST.
  - WAIT_LAST: on the cycle with `in_tvalid & in_tready & in_tlast`, go to IDLE.
- A last beat that occurs in IDLE or OFFER is ignored.
- Deasserting `out_enable` during OFFER does not withdraw or change the offered token.
- Credit update each cycle per output: new = old − consume + return, where consume is the select handshake for that index.
  - Simultaneous consume and return on the same output leaves the counter unchanged.
  - A return at MAX_CREDITS with no consume in the same cycle saturates the counter and sets `credit_overflow`.
  - Consume never happens at 0, because eligibility is checked.
- `credit_overflow` clears only on reset.
- `rr_ptr` resets to 0, so the first grant searches from index 0.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` deassert use):
  - state = IDLE, `select.valid` = 0, `select.data` = 0, `busy` = 0, `credit_overflow` = 0.
  - All credits = MAX_CREDITS, `rr_ptr` = 0.
- Reset mid-packet returns to IDLE immediately. The in-flight token is dropped and credits are restored.
- Eligible in IDLE at cycle t → `select.valid` high at t+1.
- Handshake at cycle t → WAIT_LAST at t+1. The credit decrement is visible at t+1.
- Last beat at cycle t → IDLE at t+1 → next `select.valid` at t+2, when eligible.
- Minimum token spacing is 3 cycles for single-beat packets.
- A credit return at cycle t makes the output eligible for an IDLE decision at t+1.
- All outputs are registered; there is no combinational path from inputs to `select.*`.

## Test plan
- Round-robin:
  - Stimulus: reset; all enabled; ready=1; four single-beat packets (tlast on each).
  - Required: select sequence 0,1,2,3. Output 0 credit drops to 1 after the first grant.
- Credit exhaustion, MAX_CREDITS=2:
  - Stimulus: only output 2 enabled; two packets sent; no returns.
  - Required: tokens 2,2. Third token withheld with `busy`=0. A `credit_return[2]` pulse at cycle t gives `select.valid` at t+2 with data 2.
- Stability under backpressure:
  - Stimulus: `select.ready`=0 for 5 cycles; toggle `out_enable` and pulse credit returns meanwhile.
  - Required: `select.valid`/`select.data` unchanged for all 5 cycles; one credit consumed only on the ready cycle.
- Packet boundary:
  - Stimulus: 3-beat packet to output 1; tlast asserted with `in_tready`=0 for 2 cycles, then accepted.
  - Required: no new token until the cycle after the accepted last beat.
- Overflow and simultaneity:
  - Stimulus: return to an output at MAX_CREDITS.
  - Required: `credit_overflow`=1 and credit stays at 2.
  - Stimulus: consume and return on the same output in the same cycle.
  - Required: counter unchanged.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during WAIT_LAST.
  - Required: outputs at reset values asynchronously. After release, the first grant is index 0 with full credits.

Source files
------------

// File: rtl/axi_demux_scheduler.sv
// rtl/axi_demux_scheduler.sv - packet-level round-robin select scheduler with per-output credits
module axi_demux_scheduler #(
    parameter int NUM_STREAMS = 4,
    parameter int MAX_CREDITS = 2,
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
    localparam int CW = $clog2(MAX_CREDITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   select_valid,
    input  logic                   select_ready,
    output logic [IW-1:0]          select_data,
    input  logic                   in_tvalid,
    input  logic                   in_tready,
    input  logic                   in_tlast,
    input  logic [NUM_STREAMS-1:0] out_enable,
    input  logic [NUM_STREAMS-1:0] credit_return,
    output logic                   busy,
    output logic                   credit_overflow
);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_LAST} state_t;

    state_t                   state;
    logic [IW-1:0]            rr_ptr;
    logic [CW-1:0]            credit [NUM_STREAMS];
    logic [NUM_STREAMS-1:0]   elig;
    logic [NUM_STREAMS-1:0]   consume;
    logic [IW-1:0]            pick;
    logic                     any_elig;
    logic [IW-1:0]            idx;
    logic                     last_beat;

    assign last_beat = in_tvalid & in_tready & in_tlast;

    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            elig[i] = out_enable[i] && (credit[i] != '0);
        end
    end

    // Walk downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        pick     = '0;
        any_elig = 1'b0;
        idx      = '0;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_STREAMS);
            if (elig[idx]) begin
                pick     = idx;
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        consume = '0;
        if (state == OFFER && select_ready) begin
            consume[select_data] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            select_valid <= 1'b0;
            select_data  <= '0;
            busy         <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        select_data  <= pick;
                        select_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= OFFER;
                    end
                end
                OFFER: begin
                    if (select_ready) begin
                        select_valid <= 1'b0;
                        rr_ptr       <= (select_data == IW'(NUM_STREAMS - 1)) ? '0 : select_data + IW'(1);
                        state        <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (last_beat) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    select_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // A return at a full counter saturates and flags the consumer's bookkeeping error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                credit[i] <= CW'(MAX_CREDITS);
            end
            credit_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (consume[i] && !credit_return[i]) begin
                    credit[i] <= credit[i] - CW'(1);
                end else if (!consume[i] && credit_return[i]) begin
                    if (credit[i] == CW'(MAX_CREDITS)) begin
                        credit_overflow <= 1'b1;
                    end else begin
                        credit[i] <= credit[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule
